// File: rtl/flt_pkg.sv
// flt_pkg: shared widths, packer states and the raw-sum record for the float16 result packer.
package flt_pkg;
    localparam int EXP_W = 5;
    localparam int MANT_W = 10;
    localparam logic [7:0] RES_ADDR_DEF = 8'd12;
    localparam int EXP_MAX = 31;
    typedef enum logic [2:0] {IDLE, NORM, RND, WR_LO, WR_HI} pack_state_t;
    typedef struct packed {
        logic        sign;
        logic [5:0]  exp;
        logic [11:0] mant;
        logic [2:0]  grs;
    } flt_raw_t;
endpackage

// File: rtl/flt_rne_round.sv
// flt_rne_round: round-to-nearest-even of a normalized 11-bit mantissa using its {guard, round, sticky} bits.
module flt_rne_round (
    input  logic [10:0] mant,
    input  logic [2:0]  grs,
    output logic [10:0] mant_rnd,
    output logic        carry
);
    logic        inc;
    logic [11:0] sum;
    always_comb begin
        inc = grs[2] & (grs[1] | grs[0] | mant[0]);
        sum = {1'b0, mant} + {11'd0, inc};
        carry = sum[11];
        mant_rnd = carry ? sum[11:1] : sum[10:0];
    end
endmodule

// File: rtl/flt_result_packer.sv
// flt_result_packer: renormalizes, saturates/flushes and stores a raw float16 sum as two bytes.
// Define FLT_PACK_ROUND_EN to add a round-to-nearest-even step; otherwise the mantissa is truncated.
module flt_result_packer #(
    parameter logic [7:0] RES_ADDR = flt_pkg::RES_ADDR_DEF,
    parameter int EXP_W = flt_pkg::EXP_W,
    parameter int MANT_W = flt_pkg::MANT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [5:0]  in_exp,
    input  logic [11:0] in_mant,
    input  logic [2:0]  in_grs,
    input  logic        in_zero,
    output logic [7:0]  DataAddress,
    output logic        WriteMem,
    output logic [7:0]  DataIn,
    output logic        done
);
    import flt_pkg::*;
    pack_state_t state, state_n;
    flt_raw_t r, r_n;
    logic zero_q, zero_n;
    logic sat;
    logic [EXP_W-1:0] exp_o;
    logic [MANT_W-1:0] mant_o;
`ifdef FLT_PACK_ROUND_EN
    localparam pack_state_t POST_NORM = RND;
    logic [10:0] mant_rnd;
    logic carry;
    flt_rne_round u_rnd (.mant(r.mant[10:0]), .grs(r.grs), .mant_rnd(mant_rnd), .carry(carry));
`else
    localparam pack_state_t POST_NORM = WR_LO;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            r <= '0;
            zero_q <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            r <= r_n;
            zero_q <= zero_n;
            done <= state == WR_HI || (done && !(state == IDLE && in_valid));
        end
    end

    // Zero, flush and underflow all leave NORM directly for the store, bypassing rounding.
    always_comb begin
        state_n = state;
        r_n = r;
        zero_n = zero_q;
        case (state)
            IDLE: if (in_valid) begin
                r_n = {in_sign, in_exp, in_mant, in_grs};
                zero_n = in_zero;
                state_n = NORM;
            end
            NORM: if (zero_q || r.mant == '0 || (r.mant[11:10] == 2'b00 && r.exp <= 6'd1)) begin
                r_n.exp = '0;
                r_n.mant = '0;
                state_n = WR_LO;
            end else if (r.mant[11]) begin
                r_n.mant = r.mant >> 1;
                r_n.exp = r.exp + 6'd1;
                r_n.grs = {r.mant[0], r.grs[2], r.grs[1] | r.grs[0]};
                state_n = POST_NORM;
            end else if (!r.mant[10]) begin
                r_n.mant = {r.mant[10:0], r.grs[2]};
                r_n.grs = {r.grs[1:0], r.grs[0]};
                r_n.exp = r.exp - 6'd1;
                state_n = r.mant[9] ? POST_NORM : NORM;
            end else begin
                state_n = POST_NORM;
            end
`ifdef FLT_PACK_ROUND_EN
            RND: begin
                r_n.mant = {1'b0, mant_rnd};
                r_n.exp = r.exp + {5'd0, carry};
                state_n = WR_LO;
            end
`endif
            WR_LO: state_n = WR_HI;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sat = r.exp >= 6'(EXP_MAX);
        exp_o = sat ? EXP_W'(EXP_MAX) : r.exp[EXP_W-1:0];
        mant_o = sat ? '0 : r.mant[MANT_W-1:0];
        in_ready = state == IDLE;
        WriteMem = state == WR_LO || state == WR_HI;
        DataAddress = state == WR_LO ? RES_ADDR : state == WR_HI ? RES_ADDR + 8'd1 : 8'd0;
        DataIn = state == WR_LO ? mant_o[7:0] : state == WR_HI ? {r.sign, exp_o, mant_o[MANT_W-1:8]} : 8'd0;
    end
endmodule
